// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: unit-select encodings and the
// multiply sequencer state type.
package alu_pkg;

  localparam logic [2:0] UNIT_ADD      = 3'b000;
  localparam logic [2:0] UNIT_PASS_SRC = 3'b001;
  localparam logic [2:0] UNIT_SHIFT    = 3'b010;
  localparam logic [2:0] UNIT_MUL      = 3'b011;
  localparam logic [2:0] UNIT_OR       = 3'b100;
  localparam logic [2:0] UNIT_XOR      = 3'b101;
  localparam logic [2:0] UNIT_AND      = 3'b110;
  localparam logic [2:0] UNIT_PASS_ACC = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/barrel_shift_p.sv
// Combinational logical shifter. It returns the shifted word and the last bit
// shifted out, which is 0 for a zero shift amount.
module barrel_shift_p #(
  parameter int  WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  input  logic             right,
  output logic [WIDTH-1:0] res,
  output logic             out_bit
);

  // One guard bit sits beside the word on the side the bits leave from.
  // After the shift, that guard position holds the last bit pushed out.
  logic [WIDTH:0] ext_l;
  logic [WIDTH:0] ext_r;

  assign ext_l = {1'b0, data} << amt;
  assign ext_r = {data, 1'b0} >> amt;

  always_comb begin
    if (right) begin
      res     = ext_r[WIDTH:1];
      out_bit = ext_r[0];
    end else begin
      res     = ext_l[WIDTH-1:0];
      out_bit = ext_l[WIDTH];
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU. Single-cycle operations finish at the edge that accepts
// them. An unsigned multiply runs WIDTH shift-add iterations.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [2:0]       unit_sel_in,
  input  logic             op_sel_in,
  input  logic             mul_seg_sel_in,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] src_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] alu_res_out,
  output logic             carry_out,
  output logic             zero_out
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic               accept;
  logic               mul_start;
  logic               mul_last;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_next;
  logic [SHW-1:0]     cnt_q;
  logic               seg_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_res;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   shift_res;
  logic               shift_bit;
  logic [WIDTH-1:0]   op_res;
  logic               op_carry;

  assign busy_out = (state_q == MUL);

  // Subtraction is done as acc + ~src + 1, so the carry out means "no borrow".
  assign add_sum = {1'b0, acc_in}
                 + {1'b0, (op_sel_in ? ~src_in : src_in)}
                 + {{WIDTH{1'b0}}, op_sel_in};

  barrel_shift_p #(.WIDTH(WIDTH)) u_shift (
    .data    (acc_in),
    .amt     (src_in[SHW-1:0]),
    .right   (op_sel_in),
    .res     (shift_res),
    .out_bit (shift_bit)
  );

  // NOTE: every signal written in always_comb is given a default first.
  // Without that, a path that skips an assignment infers a latch.
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    case (unit_sel_in)
      UNIT_ADD:      begin op_res = add_sum[WIDTH-1:0]; op_carry = add_sum[WIDTH]; end
      UNIT_PASS_SRC: op_res = src_in;
      UNIT_SHIFT:    begin op_res = shift_res; op_carry = shift_bit; end
      UNIT_OR:       op_res = acc_in | src_in;
      UNIT_XOR:      op_res = acc_in ^ src_in;
      UNIT_AND:      op_res = acc_in & src_in;
      UNIT_PASS_ACC: op_res = acc_in;
      default:       op_res = '0;
    endcase
  end

  // Each iteration adds the multiplicand into the high half, then shifts the
  // product right by one. The adder carry becomes the new top bit.
  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign prod_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_res   = seg_q ? prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];
  assign mul_last  = (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          accept = 1'b1;
          if (unit_sel_in == UNIT_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end
        end
      end
      MUL: begin
        if (mul_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples values from before the edge no matter how the blocks are ordered.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the multiply working registers are few and are reset along with the
  // outputs. An aborted multiply therefore leaves no stale operands behind.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alu_res_out <= '0;
      carry_out   <= 1'b0;
      zero_out    <= 1'b0;
      done_out    <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      seg_q       <= 1'b0;
    end else begin
      done_out <= 1'b0;

      if (accept && !mul_start) begin
        alu_res_out <= op_res;
        carry_out   <= op_carry;
        zero_out    <= (op_res == '0);
        done_out    <= 1'b1;
      end

      if (mul_start) begin
        mcand_q  <= acc_in;
        mplier_q <= src_in;
        prod_q   <= '0;
        cnt_q    <= '0;
        seg_q    <= mul_seg_sel_in;
      end

      if (state_q == MUL) begin
        prod_q   <= prod_next;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
        if (mul_last) begin
          alu_res_out <= mul_res;
          carry_out   <= |prod_next[2*WIDTH-1:WIDTH];
          zero_out    <= (mul_res == '0);
          done_out    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width; legal values are powers of two from 8 to 32.
REQ-002 The block SHALL have derived constant SHW, equal to log2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start_in, input, 1 bit: operation request.
REQ-006 The block SHALL have port unit_sel_in, input, 3 bits: operation select.
REQ-007 The block SHALL have port op_sel_in, input, 1 bit: subtract for add, right for shift.
REQ-008 The block SHALL have port mul_seg_sel_in, input, 1 bit: 1 selects the high half of the product, 0 the low half.
REQ-009 The block SHALL have ports acc_in and src_in, input, WIDTH bits each: operands.
REQ-010 The block SHALL have port busy_out, output, 1 bit: multiply in progress.
REQ-011 The block SHALL have port done_out, output, 1 bit: one-cycle result-valid pulse.
REQ-012 The block SHALL have port alu_res_out, output, WIDTH bits: registered result.
REQ-013 The block SHALL have ports carry_out and zero_out, output, 1 bit each: registered flags.

Function
REQ-014 Acceptance: the block SHALL accept an operation on any rising edge where start_in=1 and busy_out=0, including the cycle in which done_out=1.
REQ-015 The block SHALL sample all operands and selects only at the accepting edge; input changes while busy_out=1 SHALL have no effect.
REQ-016 While busy_out=1, start_in SHALL be ignored: no queueing and no effect on the result.
REQ-017 The block SHALL implement the following unit_sel_in encodings:
- 000: add, or subtract when op_sel_in=1 (computed as acc + ~src + 1).
- 001: pass src.
- 010: logical shift of acc by src[SHW-1:0], left when op_sel_in=0, right when op_sel_in=1.
- 011: unsigned multiply.
- 100: OR.
- 101: XOR.
- 110: AND.
- 111: pass acc.
REQ-018 Non-multiply operations SHALL update alu_res_out, carry_out and zero_out at the accepting edge, and SHALL assert done_out for exactly the following cycle.
REQ-019 Back-to-back non-multiply operations SHALL complete at one per cycle.
REQ-020 Multiply SHALL use a two-state FSM, IDLE and MUL.
REQ-021 On an accepted multiply, the FSM SHALL move IDLE->MUL at the accepting edge E0, and the block SHALL load the multiplicand, multiplier, a 2*WIDTH-bit zeroed partial product and a counter.
REQ-022 In MUL, the block SHALL perform one shift-add iteration per edge, E1..E_WIDTH; at E_WIDTH it SHALL write the selected product half to alu_res_out, set done_out=1 and busy_out=0, and return the FSM to IDLE.
REQ-023 busy_out SHALL be 1 exactly for the cycles following edges E0..E_WIDTH-1, that is WIDTH cycles.
REQ-024 The carry_out rules SHALL be:
- Add: the adder carry out of bit WIDTH-1.
- Subtract: the same carry (1 = no borrow).
- Shift: the last bit shifted out, or 0 when the shift amount is 0.
- Multiply: 1 when the high product half is non-zero, regardless of mul_seg_sel_in.
- All other operations: 0.
REQ-025 zero_out SHALL be 1 exactly when the newly written alu_res_out equals 0.
REQ-026 Add and subtract SHALL wrap modulo 2^WIDTH.
REQ-027 alu_res_out and both flags SHALL hold their values until the next completion.
REQ-028 done_out SHALL never be asserted for two consecutive cycles for the same operation.

Reset
REQ-029 While rst_in=1, asynchronously, the block SHALL force the FSM to IDLE and drive alu_res_out=0, carry_out=0, zero_out=0, busy_out=0 and done_out=0.
REQ-030 A reset during MUL SHALL abort the multiply with no done_out pulse and no partial result visible.
REQ-031 The first operation SHALL be accepted on the first rising edge after rst_in deasserts.

Structure
REQ-032 Shared package alu_pkg SHALL hold the unit_sel encodings as named constants and the FSM state type.
REQ-033 The block SHALL contain one sub-module, barrel_shift_p: a combinational shifter parametrised by WIDTH, giving the result and the shifted-out bit, instantiated once.
REQ-034 The adder, logic operations and multiplier datapath SHALL be inline in seq_alu.

Verification
REQ-035 WIDTH=8, add 0xFF+0x01 -> next cycle alu_res_out=0x00, carry_out=1, zero_out=1, done_out=1 for one cycle.
REQ-036 WIDTH=8, subtract 0x05-0x07 -> alu_res_out=0xFE, carry_out=0, zero_out=0; then subtract 0x07-0x05 on the next cycle -> alu_res_out=0x02, carry_out=1.
REQ-037 WIDTH=8, shift right of acc=0x81 by src=1 -> alu_res_out=0x40, carry_out=1; then shift left by 0 -> alu_res_out=0x81, carry_out=0.
REQ-038 WIDTH=8, multiply 0xFF*0xFF with mul_seg_sel_in=1 -> busy_out=1 for 8 cycles, then alu_res_out=0xFE, carry_out=1; a start_in pulse during busy -> no effect.
REQ-039 WIDTH=8, multiply 0x12*0x34, rst_in pulsed after E4 -> all outputs 0, no done_out; a new add accepted on the first edge after reset -> done_out after 1 cycle.
REQ-040 WIDTH=16, multiply 0x1234*0x0010 with mul_seg_sel_in=0 -> after 16 busy cycles alu_res_out=0x2340, carry_out=1.
